// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields into 32-bit instruction words.
// Each word gets the next instruction-memory byte address. Immediates that
// cannot be represented in the chosen format are truncated and reported.
// A single output register stage sits on a valid/ready stream.
module instr_encoder #(
    parameter int              ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [31:0]       NOP_INSTR = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(3'd4);

    // The immediate fits a signed field when every bit selected by the mask
    // equals the sign bit, i.e. the masked bits are all zero or all one.
    function automatic logic fits_signed(input logic [31:0] v, input logic [31:0] mask);
        logic [31:0] sel;
        sel = v & mask;
        return (sel == mask) || (sel == 32'h0000_0000);
    endfunction

    logic              accept_s;
    logic [31:0]       enc_instr_s;
    logic              enc_err_s;
    logic [ADDR_W-1:0] cur_addr_s;
    logic [ADDR_W-1:0] addr_r;

    assign in_ready = !out_valid || out_ready;
    assign accept_s = in_valid && in_ready;
    // A clear in the same cycle as an accept hands the word BASE_ADDR.
    assign cur_addr_s = clear ? BASE_ADDR : addr_r;

    // Pack the fields for the requested format and range-check the immediate.
    always_comb begin
        enc_instr_s = NOP_INSTR;
        enc_err_s   = 1'b0;
        case (in_fmt)
            FMT_R: begin
                enc_instr_s = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                enc_err_s   = 1'b0;
            end
            FMT_I: begin
                enc_instr_s = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                enc_err_s   = !fits_signed(in_imm, 32'hFFFF_F800);
            end
            FMT_S: begin
                enc_instr_s = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                enc_err_s   = !fits_signed(in_imm, 32'hFFFF_F800);
            end
            FMT_B: begin
                enc_instr_s = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                               in_imm[4:1], in_imm[11], in_opcode};
                enc_err_s   = !fits_signed(in_imm, 32'hFFFF_F000) || in_imm[0];
            end
            FMT_U: begin
                enc_instr_s = {in_imm[31:12], in_rd, in_opcode};
                enc_err_s   = (in_imm[11:0] != 12'h000);
            end
            FMT_J: begin
                enc_instr_s = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                enc_err_s   = !fits_signed(in_imm, 32'hFFF0_0000) || in_imm[0];
            end
            default: begin
                enc_instr_s = NOP_INSTR;
                enc_err_s   = 1'b1;
            end
        endcase
    end

    // Output register: load on accept, drop valid after a transfer, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= 32'h0000_0000;
            out_addr  <= {ADDR_W{1'b0}};
        end else if (accept_s) begin
            out_valid <= 1'b1;
            out_instr <= enc_instr_s;
            out_addr  <= cur_addr_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

    // Address counter: advances by one word per accept, wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r <= BASE_ADDR;
        end else if (accept_s) begin
            addr_r <= cur_addr_s + ADDR_STEP;
        end else if (clear) begin
            addr_r <= BASE_ADDR;
        end else begin
            addr_r <= addr_r;
        end
    end

    // Sticky error flag with the address of the first offending word.
    always_ff @(posedge clk) begin
        if (rst) begin
            err      <= 1'b0;
            err_addr <= {ADDR_W{1'b0}};
        end else if (clear) begin
            err      <= accept_s && enc_err_s;
            err_addr <= {ADDR_W{1'b0}};
            if (accept_s && enc_err_s) begin
                err_addr <= BASE_ADDR;
            end else begin
                err_addr <= {ADDR_W{1'b0}};
            end
        end else if (accept_s && enc_err_s) begin
            err <= 1'b1;
            if (!err) begin
                err_addr <= cur_addr_s;
            end else begin
                err_addr <= err_addr;
            end
        end else begin
            err      <= err;
            err_addr <= err_addr;
        end
    end

endmodule
